vga_timing_gen: RTL and testbench

- Raster timing source for the 640x480 VGA display path. Produces the pixel-enable strobe, the horizontal and vertical pixel counters, the sync pulses and the active-video flag.
- Every sprite and target renderer consumes its x/y/pix_clk outputs and decodes them into pixel hits.
- frame_tick is the once-per-frame strobe that drives sprite animation updates. It is issued in vertical blanking so position registers never change mid-scan.

---
 rtl/vga_timing_gen.sv | 95 +++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel strobe, x/y counters, syncs, active video, frame tick
module vga_timing_gen #(
    parameter int   CLK_DIV     = 2,
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_clk,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       V_ACT10  = 10'(V_ACTIVE);

    // Decode bounds are 11 bits so an end bound of exactly 1024 stays representable.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be in 1..16");
    end

    logic [DIV_W-1:0] div;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic [10:0]      x_ext;
    logic [10:0]      y_ext;

    always_comb begin
        x_next = x;
        y_next = y;
        if (pix_clk) begin
            if (x == H_LAST) begin
                x_next = 10'd0;
                y_next = (y == V_LAST) ? 10'd0 : y + 10'd1;
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    assign x_ext = {1'b0, x_next};
    assign y_ext = {1'b0, y_next};

    // Sync/video decodes use next-state counters so they land on the same edge as x/y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div        <= '0;
            pix_clk    <= 1'b0;
            x          <= 10'd0;
            y          <= 10'd0;
            video_on   <= 1'b1;
            hsync      <= ~SYNC_ACTIVE;
            vsync      <= ~SYNC_ACTIVE;
            frame_tick <= 1'b0;
        end else begin
            div        <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            pix_clk    <= (div == DIV_LAST);
            x          <= x_next;
            y          <= y_next;
            video_on   <= (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
            hsync      <= (x_ext >= HS_START && x_ext < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync      <= (y_ext >= VS_START && y_ext < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            // Only an advancing edge can arrive at (0,V_ACTIVE), so the pulse is one clk wide.
            frame_tick <= pix_clk && (x_next == 10'd0) && (y_next == V_ACT10);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (full, fast and small-geometry instances)
module tb_vga_timing_gen;

    typedef struct {
        int         cyc;
        logic [9:0] x;
        logic [9:0] y;
        logic       pc;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ft;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   cyc_a = 0;
    int   cyc_b = 0;
    int   errors = 0;
    int   checks = 0;

    logic       pc_f, von_f, hs_f, vs_f, ft_f;
    logic [9:0] x_f, y_f;
    logic       pc_q, von_q, hs_q, vs_q, ft_q;
    logic [9:0] x_q, y_q;
    logic       pc_s, von_s, hs_s, vs_s, ft_s;
    logic [9:0] x_s, y_s;

    exp_t q_full[$], q_fast[$], q_small[$];
    exp_t h_full[$], h_fast[$], h_small[$];
    exp_t e_f, e_q, e_s;

    vga_timing_gen u_full (
        .clk(clk), .rst(rst_a), .pix_clk(pc_f), .x(x_f), .y(y_f),
        .video_on(von_f), .hsync(hs_f), .vsync(vs_f), .frame_tick(ft_f)
    );

    vga_timing_gen #(.CLK_DIV(1), .SYNC_ACTIVE(1'b1)) u_fast (
        .clk(clk), .rst(rst_a), .pix_clk(pc_q), .x(x_q), .y(y_q),
        .video_on(von_q), .hsync(hs_q), .vsync(vs_q), .frame_tick(ft_q)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_ACTIVE(1'b0)
    ) u_small (
        .clk(clk), .rst(rst_b), .pix_clk(pc_s), .x(x_s), .y(y_s),
        .video_on(von_s), .hsync(hs_s), .vsync(vs_s), .frame_tick(ft_s)
    );

    // cyc counts posedges since the first edge with reset released; 0 while in reset
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) cyc_a <= 0;
        else        cyc_a <= cyc_a + 1;
    end
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) cyc_b <= 0;
        else        cyc_b <= cyc_b + 1;
    end

    function automatic exp_t mk(input int c, input int xv, input int yv,
                                input logic pc, input logic hs, input logic vs,
                                input logic von, input logic ft);
        exp_t r;
        r.cyc = c; r.x = 10'(xv); r.y = 10'(yv);
        r.pc = pc; r.hs = hs; r.vs = vs; r.von = von; r.ft = ft;
        return r;
    endfunction

    // Pixel n is reached after edge 1+n*d; strobe is high after every d-th edge.
    function automatic exp_t model(input int c, input int d,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input logic sa);
        int ht, vt, n, xx, yy;
        logic adv;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (c == 0) return mk(0, 0, 0, 1'b0, ~sa, ~sa, 1'b1, 1'b0);
        n   = (c - 1) / d;
        xx  = n % ht;
        yy  = (n / ht) % vt;
        adv = ((c - 1) % d == 0) && (c > d);
        return mk(c, xx, yy, (c % d) == 0,
                  (xx >= ha + hf && xx < ha + hf + hsw) ? sa : ~sa,
                  (yy >= va + vf && yy < va + vf + vsw) ? sa : ~sa,
                  (xx < ha) && (yy < va),
                  adv && xx == 0 && yy == va);
    endfunction

    task automatic push_range(input int which, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            case (which)
                0: begin
                    q_full.push_back(model(c, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
                    foreach (h_full[i]) if (h_full[i].cyc == c) q_full.push_back(h_full[i]);
                end
                1: begin
                    q_fast.push_back(model(c, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1));
                    foreach (h_fast[i]) if (h_fast[i].cyc == c) q_fast.push_back(h_fast[i]);
                end
                default: begin
                    q_small.push_back(model(c, 2, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0));
                    foreach (h_small[i]) if (h_small[i].cyc == c) q_small.push_back(h_small[i]);
                end
            endcase
        end
    endtask

    task automatic compare(input string nm, input exp_t e, input exp_t a);
        checks++;
        if (a.x !== e.x || a.y !== e.y || a.pc !== e.pc || a.hs !== e.hs ||
            a.vs !== e.vs || a.von !== e.von || a.ft !== e.ft) begin
            errors++;
            $display("FAIL %s cyc=%0d actual x=%0d y=%0d pc=%b hs=%b vs=%b von=%b ft=%b required x=%0d y=%0d pc=%b hs=%b vs=%b von=%b ft=%b",
                     nm, e.cyc, a.x, a.y, a.pc, a.hs, a.vs, a.von, a.ft,
                     e.x, e.y, e.pc, e.hs, e.vs, e.von, e.ft);
        end
    endtask

    task automatic missed(input string nm, input int want, input int now);
        checks++;
        errors++;
        $display("FAIL %s_missed actual cyc=%0d required cyc=%0d", nm, now, want);
    endtask

    always @(negedge clk) begin
        while (q_full.size() > 0 && q_full[0].cyc <= cyc_a) begin
            e_f = q_full.pop_front();
            if (e_f.cyc < cyc_a) missed("full", e_f.cyc, cyc_a);
            else compare("full", e_f, mk(cyc_a, int'(x_f), int'(y_f), pc_f, hs_f, vs_f, von_f, ft_f));
        end
    end

    always @(negedge clk) begin
        while (q_fast.size() > 0 && q_fast[0].cyc <= cyc_a) begin
            e_q = q_fast.pop_front();
            if (e_q.cyc < cyc_a) missed("fast", e_q.cyc, cyc_a);
            else compare("fast", e_q, mk(cyc_a, int'(x_q), int'(y_q), pc_q, hs_q, vs_q, von_q, ft_q));
        end
    end

    always @(negedge clk) begin
        while (q_small.size() > 0 && q_small[0].cyc <= cyc_b) begin
            e_s = q_small.pop_front();
            if (e_s.cyc < cyc_b) missed("small", e_s.cyc, cyc_b);
            else compare("small", e_s, mk(cyc_b, int'(x_s), int'(y_s), pc_s, hs_s, vs_s, von_s, ft_s));
        end
    end

    task automatic drain(input int limit);
        int k = 0;
        while ((q_full.size() + q_fast.size() + q_small.size()) > 0 && k < limit) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if ((q_full.size() + q_fast.size() + q_small.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout actual pending=%0d required 0",
                     q_full.size() + q_fast.size() + q_small.size());
        end
    endtask

    initial begin
        // hand-computed boundary vectors: cyc, x, y, pix_clk, hsync, vsync, video_on, frame_tick
        h_full.push_back(mk(1,    0,   0, 0, 1, 1, 1, 0));
        h_full.push_back(mk(2,    0,   0, 1, 1, 1, 1, 0));
        h_full.push_back(mk(3,    1,   0, 0, 1, 1, 1, 0));
        h_full.push_back(mk(1280, 639, 0, 1, 1, 1, 1, 0));
        h_full.push_back(mk(1281, 640, 0, 0, 1, 1, 0, 0));
        h_full.push_back(mk(1313, 656, 0, 0, 0, 1, 0, 0));
        h_full.push_back(mk(1504, 751, 0, 1, 0, 1, 0, 0));
        h_full.push_back(mk(1505, 752, 0, 0, 1, 1, 0, 0));
        h_full.push_back(mk(1600, 799, 0, 1, 1, 1, 0, 0));
        h_full.push_back(mk(1601, 0,   1, 0, 1, 1, 1, 0));

        h_fast.push_back(mk(1,   0,   0, 1, 0, 0, 1, 0));
        h_fast.push_back(mk(641, 640, 0, 1, 0, 0, 0, 0));
        h_fast.push_back(mk(657, 656, 0, 1, 1, 0, 0, 0));
        h_fast.push_back(mk(752, 751, 0, 1, 1, 0, 0, 0));
        h_fast.push_back(mk(753, 752, 0, 1, 0, 0, 0, 0));
        h_fast.push_back(mk(801, 0,   1, 1, 0, 0, 1, 0));

        h_small.push_back(mk(21,  10, 0, 0, 0, 1, 0, 0));
        h_small.push_back(mk(179, 14, 5, 0, 1, 1, 0, 0));
        h_small.push_back(mk(181, 0,  6, 0, 1, 1, 0, 1));
        h_small.push_back(mk(182, 0,  6, 1, 1, 1, 0, 0));
        h_small.push_back(mk(211, 0,  7, 0, 1, 0, 0, 0));
        h_small.push_back(mk(271, 0,  9, 0, 1, 1, 0, 0));
        h_small.push_back(mk(299, 14, 9, 0, 1, 1, 0, 0));
        h_small.push_back(mk(301, 0,  0, 0, 1, 1, 1, 0));
        h_small.push_back(mk(481, 0,  6, 0, 1, 1, 0, 1));
        h_small.push_back(mk(781, 0,  6, 0, 1, 1, 0, 1));

        q_full.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
        q_fast.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
        q_small.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0));
        repeat (5) @(posedge clk);
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        push_range(0, 1, 1610);
        push_range(1, 1, 1700);
        push_range(2, 1, 805);
        drain(2000);

        // mid-frame reset on the small instance, asserted between edges
        push_range(2, 0, 0);
        #2 rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_b = 1'b1;
        push_range(2, 1, 80);
        begin
            int k;
            k = 0;
            while (k < 300) begin
                @(posedge clk);
                #1;
                if (cyc_b == 81) break;
                k++;
            end
            checks++;
            if (cyc_b != 81) begin
                errors++;
                $display("FAIL wait_cyc81 actual cyc=%0d required 81", cyc_b);
            end
        end
        push_range(2, 0, 0);
        #1 rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_b = 1'b1;
        push_range(2, 1, 200);
        drain(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
